sigmoid_sched: RTL and testbench

//  Round-robin scheduler that shares one sigmoid activation engine (start/done, active-low-reset protocol) between R neuron-layer requesters.

---
 rtl/sigmoid_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_sigmoid_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_sched.sv
`default_nettype none
// ============================================================================
// Module   : sigmoid_sched
// Purpose  : Round-robin scheduler sharing one sigmoid engine (start/done,
//            active-low reset) between R requesters. Latches the winner's
//            operand vector, resets and starts the engine, waits for done and
//            returns the result with a one-cycle one-hot ack.
// Options  : SIGMOID_SCHED_TIMEOUT_EN - WAIT-state timeout with err pulse
// Revision : 1.0 - initial release
// ============================================================================
module sigmoid_sched #(
    parameter int S       = 32,
    parameter int N       = 2,
    parameter int R       = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R-1:0]         req,
    input  logic [R*S*N-1:0]     x_in,
    output logic [R-1:0]         ack,
    output logic [S*N-1:0]       y_out,
    output logic                 y_valid,
    output logic [$clog2(R)-1:0] grant_id,
    output logic                 busy,
    output logic                 err,
    output logic                 sig_rst_n,
    output logic                 sig_start,
    output logic [S*N-1:0]       sig_x,
    input  logic [S*N-1:0]       sig_y,
    input  logic                 sig_done
);

    localparam int c_gw = $clog2(R);
    localparam int c_vw = S * N;

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_issue = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;
    localparam logic [1:0] c_resp  = 2'd3;

    // Reject configurations the arbiter cannot handle at elaboration time
    generate
        if (R < 2 || TIMEOUT < 1) begin : g_param_check
            $error("sigmoid_sched: R must be >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    logic [1:0]      r_state, w_state_nxt;
    logic [c_gw-1:0] r_last, w_last_nxt;
    logic [c_gw-1:0] r_grant, w_grant_nxt;
    logic [c_vw-1:0] r_sig_x, w_sig_x_nxt;
    logic [c_vw-1:0] r_y_out, w_y_out_nxt;
    logic [R-1:0]    r_ack, w_ack_nxt;
    logic            r_y_valid, w_y_valid_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_err, w_err_nxt;
    logic            r_sig_start, w_sig_start_nxt;
    logic            r_sig_rst_n, w_sig_rst_n_nxt;
    logic            r_wait_first, w_wait_first_nxt;

    logic            w_any;
    logic            w_found;
    logic [c_gw-1:0] w_idx;
    logic [c_gw-1:0] w_win;
    logic [c_vw-1:0] w_x_sel;
    logic            w_timeout;

    // Round-robin search starting one past the last served requester
    always_comb begin
        w_any   = |req;
        w_found = 1'b0;
        w_win   = r_last;
        w_idx   = r_last;
        for (int k = 1; k <= R; k++) begin
            w_idx = c_gw'((int'(r_last) + k) % R);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Operand mux for the arbitration winner
    always_comb begin
        w_x_sel = '0;
        for (int i = 0; i < R; i++) begin
            if (w_win == c_gw'(i)) begin
                w_x_sel = x_in[i*c_vw +: c_vw];
            end
        end
    end

`ifdef SIGMOID_SCHED_TIMEOUT_EN
    localparam int c_tw = $clog2(TIMEOUT + 1);
    logic [c_tw-1:0] r_tmo_cnt;

    // WAIT-cycle counter, cleared in ISSUE so each operation starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_issue) begin
            r_tmo_cnt <= '0;
        end else if (r_state == c_wait) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == c_wait) && (r_tmo_cnt == c_tw'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the first WAIT cycle ignores a done left over from the previous op
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (w_any) w_state_nxt = c_issue;
            c_issue: w_state_nxt = c_wait;
            c_wait:  if (!r_wait_first && (sig_done || w_timeout)) w_state_nxt = c_resp;
            c_resp:  w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        w_sig_x_nxt      = r_sig_x;
        w_grant_nxt      = r_grant;
        w_y_out_nxt      = r_y_out;
        w_last_nxt       = r_last;
        w_ack_nxt        = '0;
        w_y_valid_nxt    = 1'b0;
        w_err_nxt        = 1'b0;
        w_sig_start_nxt  = 1'b0;
        w_sig_rst_n_nxt  = 1'b1;
        w_wait_first_nxt = 1'b0;
        w_busy_nxt       = (w_state_nxt != c_idle);
        case (r_state)
            c_idle: begin
                if (w_any) begin
                    w_grant_nxt     = w_win;
                    w_sig_x_nxt     = w_x_sel;
                    w_sig_start_nxt = 1'b1;
                    w_sig_rst_n_nxt = 1'b0;
                end
            end
            c_issue: begin
                w_wait_first_nxt = 1'b1;
            end
            c_wait: begin
                if (!r_wait_first) begin
                    if (sig_done) begin
                        w_y_out_nxt          = sig_y;
                        w_ack_nxt[r_grant]   = 1'b1;
                        w_y_valid_nxt        = 1'b1;
                    end else if (w_timeout) begin
                        w_y_out_nxt          = '0;
                        w_ack_nxt[r_grant]   = 1'b1;
                        w_y_valid_nxt        = 1'b1;
                        w_err_nxt            = 1'b1;
                    end
                end
            end
            c_resp: begin
                w_last_nxt = r_grant;
            end
            default: ;
        endcase
    end

    // Output registers; reset holds the engine in reset and gives requester 0 priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig_x      <= '0;
            r_grant      <= '0;
            r_y_out      <= '0;
            r_last       <= c_gw'(R - 1);
            r_ack        <= '0;
            r_y_valid    <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_sig_start  <= 1'b0;
            r_sig_rst_n  <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_sig_x      <= w_sig_x_nxt;
            r_grant      <= w_grant_nxt;
            r_y_out      <= w_y_out_nxt;
            r_last       <= w_last_nxt;
            r_ack        <= w_ack_nxt;
            r_y_valid    <= w_y_valid_nxt;
            r_err        <= w_err_nxt;
            r_busy       <= w_busy_nxt;
            r_sig_start  <= w_sig_start_nxt;
            r_sig_rst_n  <= w_sig_rst_n_nxt;
            r_wait_first <= w_wait_first_nxt;
        end
    end

    assign ack       = r_ack;
    assign y_out     = r_y_out;
    assign y_valid   = r_y_valid;
    assign grant_id  = r_grant;
    assign busy      = r_busy;
    assign err       = r_err;
    assign sig_rst_n = r_sig_rst_n;
    assign sig_start = r_sig_start;
    assign sig_x     = r_sig_x;

endmodule
`default_nettype wire

// File: tb/tb_sigmoid_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigmoid_sched
// Purpose  : Self-checking bench for sigmoid_sched with a behavioural engine
//            model (done L cycles after start, y = x ^ sign mask).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigmoid_sched;

    localparam int S = 32;
    localparam int N = 2;
    localparam int R = 4;
    localparam int TMO = 16;
    localparam logic [63:0] c_mask = {2{32'h8000_0000}};

    logic           clk = 1'b0;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*64-1:0] x_in;
    logic [R-1:0]   ack;
    logic [63:0]    y_out;
    logic           y_valid;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err;
    logic           sig_rst_n;
    logic           sig_start;
    logic [63:0]    sig_x;
    logic [63:0]    sig_y;
    logic           sig_done;

    int n_checks;
    int n_errors;

    always #5 clk = ~clk;

    sigmoid_sched #(.S(S), .N(N), .R(R), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .x_in(x_in),
        .ack(ack), .y_out(y_out), .y_valid(y_valid), .grant_id(grant_id),
        .busy(busy), .err(err), .sig_rst_n(sig_rst_n), .sig_start(sig_start),
        .sig_x(sig_x), .sig_y(sig_y), .sig_done(sig_done)
    );

    // Engine model: done L cycles after start; optional one-cycle-late reset
    // (leaves a stale done visible in the first WAIT cycle) and never-done mode.
    int          eng_L = 5;
    bit          eng_lag = 1'b0;
    bit          eng_never = 1'b0;
    logic        eng_run = 1'b0;
    logic        eng_done = 1'b0;
    logic        eng_rst_d = 1'b0;
    int          eng_cnt = 0;
    logic [63:0] eng_y = '0;

    always @(posedge clk) begin
        eng_rst_d <= sig_rst_n;
        if (sig_start) begin
            eng_run <= 1'b1;
            eng_cnt <= 1;
            eng_y   <= sig_x ^ c_mask;
        end else if (!sig_rst_n) begin
            eng_run <= 1'b0;
        end else if (eng_run) begin
            if (eng_cnt >= eng_L) eng_run <= 1'b0;
            else eng_cnt <= eng_cnt + 1;
        end
        if (eng_run && eng_cnt >= eng_L && sig_rst_n && !sig_start && !eng_never)
            eng_done <= 1'b1;
        else if (eng_lag ? !eng_rst_d : !sig_rst_n)
            eng_done <= 1'b0;
    end

    assign sig_y    = eng_y;
    assign sig_done = eng_done;

    // Fixed operand set used by the vector table and hand sequences
    logic [63:0] xv [R];
    logic [63:0] yv [R];

    typedef struct {
        logic [R-1:0] rq;
        int           w;
    } vec_t;
    vec_t tbl [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load_fixed_x();
        for (int i = 0; i < R; i++) x_in[i*64 +: 64] = xv[i];
    endtask

    // Reference round-robin choice straight from the fairness rule
    function automatic int rr_pick(input logic [R-1:0] rq, input int last);
        for (int k = 1; k <= R; k++)
            if (rq[(last + k) % R]) return (last + k) % R;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        chk("rst_ack", 64'(ack), 0);
        chk("rst_yv", 64'(y_valid), 0);
        chk("rst_yout", y_out, 0);
        chk("rst_sigx", sig_x, 0);
        chk("rst_gid", 64'(grant_id), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_start", 64'(sig_start), 0);
        chk("rst_srstn", 64'(sig_rst_n), 0);
        rst = 1'b0;
        step();
        chk("idle_srstn", 64'(sig_rst_n), 1);
    endtask

    // One operation: drive req, check the issue cycle, wait for ack, check
    // response cycle and the cycle after it.
    task automatic run_op(input logic [R-1:0] rq, input int w, input logic [63:0] ex,
                          input logic [63:0] ey, input int lat, input logic eerr,
                          input bit drop, input bit scramble, input bit hold,
                          input string tag);
        int n;
        req = rq;
        step();
        chk({tag, "_start"}, 64'(sig_start), 1);
        chk({tag, "_srstn"}, 64'(sig_rst_n), 0);
        chk({tag, "_sigx"}, sig_x, ex);
        chk({tag, "_gid"}, 64'(grant_id), 64'(w));
        if (drop) req = '0;
        if (scramble) for (int i = 0; i < R; i++) x_in[i*64 +: 64] = {$urandom, $urandom};
        n = 0;
        while (ack == '0 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_ack"}, 64'(ack), 64'(1 << w));
        chk({tag, "_yv"}, 64'(y_valid), 1);
        chk({tag, "_yout"}, y_out, ey);
        chk({tag, "_err"}, 64'(err), 64'(eerr));
        if (!hold && !drop) req = '0;
        step();
        chk({tag, "_ack0"}, 64'(ack), 0);
        chk({tag, "_yv0"}, 64'(y_valid), 0);
        chk({tag, "_yhold"}, y_out, ey);
        chk({tag, "_idle"}, 64'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rlast;
        int w;
        int lat;
        logic [R-1:0] rq;
        logic [63:0] ex;
        bit drop;
        bit scr;
        bit seen;

        n_checks = 0;
        n_errors = 0;
        xv[0] = 64'h00000000_40a00000;
        xv[1] = 64'h3f800000_bf800000;
        xv[2] = 64'h12345678_9abcdef0;
        xv[3] = 64'hffffffff_00000001;
        yv[0] = 64'h80000000_c0a00000;
        yv[1] = 64'hbf800000_3f800000;
        yv[2] = 64'h92345678_1abcdef0;
        yv[3] = 64'h7fffffff_80000001;
        // Round-robin sequence from reset (last = 3)
        tbl[0] = '{4'b0001, 0};
        tbl[1] = '{4'b0010, 1};
        tbl[2] = '{4'b1001, 3};
        tbl[3] = '{4'b1001, 0};
        tbl[4] = '{4'b0110, 1};
        tbl[5] = '{4'b0101, 2};
        tbl[6] = '{4'b1111, 3};
        tbl[7] = '{4'b0100, 2};

        x_in = '0;
        load_fixed_x();
        do_reset();

        for (int t = 0; t < 8; t++)
            run_op(tbl[t].rq, tbl[t].w, xv[tbl[t].w], yv[tbl[t].w], 7, 1'b0, 0, 0, 0,
                   $sformatf("tbl%0d", t));

        // Stale done from the previous op must not end the next op early
        eng_lag = 1'b1;
        run_op(4'b0001, 0, xv[0], yv[0], 7, 1'b0, 0, 0, 0, "stale1");
        run_op(4'b0001, 0, xv[0], yv[0], 7, 1'b0, 0, 0, 0, "stale2");
        eng_lag = 1'b0;

        // All requesters held: grant order 0,1,2,3,0 back to back
        do_reset();
        for (int i = 0; i < 5; i++)
            run_op(4'b1111, i % R, xv[i % R], yv[i % R], 7, 1'b0, 0, 0, (i < 4),
                   $sformatf("rr%0d", i));

        // One-cycle request pulse still completes, and nothing follows it
        run_op(4'b0100, 2, xv[2], yv[2], 7, 1'b0, 1, 0, 0, "pulse");
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (sig_start || busy) seen = 1'b1;
        end
        chk("pulse_no_second", 64'(seen), 0);

        // Reset during WAIT drops the op and forces the engine into reset
        req = 4'b0010;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mid_srstn", 64'(sig_rst_n), 0);
        chk("mid_ack", 64'(ack), 0);
        chk("mid_yv", 64'(y_valid), 0);
        chk("mid_busy", 64'(busy), 0);
        chk("mid_yout", y_out, 0);
        step();
        step();
        rst = 1'b0;
        run_op(4'b0010, 1, xv[1], yv[1], 7, 1'b0, 0, 0, 0, "after_rst");

        // Randomized traffic against the reference arbitration model
        do_reset();
        rlast = R - 1;
        for (int t = 0; t < 40; t++) begin
            rq = 4'($urandom_range(1, 15));
            for (int i = 0; i < R; i++) x_in[i*64 +: 64] = {$urandom, $urandom};
            eng_L = int'($urandom_range(1, 8));
            w = rr_pick(rq, rlast);
            ex = x_in[w*64 +: 64];
            lat = eng_L + 2;
            drop = 1'($urandom_range(0, 1));
            scr = 1'($urandom_range(0, 1));
            run_op(rq, w, ex, ex ^ c_mask, lat, 1'b0, drop, scr, 0, $sformatf("rnd%0d", t));
            rlast = w;
        end
        eng_L = 5;

`ifdef SIGMOID_SCHED_TIMEOUT_EN
        // Engine never finishes: timeout after TMO WAIT cycles with err and zero result
        load_fixed_x();
        eng_never = 1'b1;
        run_op(4'b0001, 0, xv[0], 64'h0, TMO + 1, 1'b1, 0, 0, 0, "tmo");
        eng_never = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
